// File: rtl/cv32e40x_xif_offload_ctrl.sv
// Core-side XIF initiator: offloads one instruction at a time through issue, commit/kill and
// result write-back, with a sequential instruction id that wraps at 2^X_ID_WIDTH.
module cv32e40x_xif_offload_ctrl #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFR_WIDTH = 32,
  parameter int unsigned X_RFW_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   offload_valid_i,
  output logic                   offload_ready_o,
  input  logic [31:0]            offload_instr_i,
  input  logic [X_RFR_WIDTH-1:0] offload_rs1_i,
  input  logic [X_RFR_WIDTH-1:0] offload_rs2_i,
  input  logic                   flush_i,
  output logic                   x_issue_valid_o,
  input  logic                   x_issue_ready_i,
  output logic [31:0]            x_issue_instr_o,
  output logic [X_ID_WIDTH-1:0]  x_issue_id_o,
  output logic [X_RFR_WIDTH-1:0] x_issue_rs0_o,
  output logic [X_RFR_WIDTH-1:0] x_issue_rs1_o,
  output logic [1:0]             x_issue_rs_valid_o,
  input  logic                   x_issue_accept_i,
  input  logic                   x_issue_writeback_i,
  output logic                   x_commit_valid_o,
  output logic [X_ID_WIDTH-1:0]  x_commit_id_o,
  output logic                   x_commit_kill_o,
  input  logic                   x_result_valid_i,
  output logic                   x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]  x_result_id_i,
  input  logic [X_RFW_WIDTH-1:0] x_result_data_i,
  input  logic [4:0]             x_result_rd_i,
  input  logic                   x_result_we_i,
  output logic                   rf_we_o,
  output logic [4:0]             rf_waddr_o,
  output logic [X_RFW_WIDTH-1:0] rf_wdata_o,
  output logic                   illegal_o,
  output logic                   id_err_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMMIT   = 2'd2,
    WAIT_RES = 2'd3
  } state_e;

  state_e                 state_r, state_s;
  logic [31:0]            instr_r;
  logic [X_RFR_WIDTH-1:0] rs1_r, rs2_r;
  logic [X_ID_WIDTH-1:0]  id_r;
  logic                   kill_pending_r, writeback_r;
  logic                   rf_we_r, illegal_r, id_err_r;
  logic [4:0]             rf_waddr_r;
  logic [X_RFW_WIDTH-1:0] rf_wdata_r;

  logic offload_hs_s, issue_hs_s, result_take_s, kill_s, id_inc_s;
  logic illegal_s, id_err_s, rf_we_s;

  // Next-state and handshake decode
  always_comb begin
    state_s       = state_r;
    offload_hs_s  = 1'b0;
    issue_hs_s    = 1'b0;
    result_take_s = 1'b0;
    kill_s        = 1'b0;
    id_inc_s      = 1'b0;
    illegal_s     = 1'b0;
    id_err_s      = 1'b0;
    rf_we_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (offload_valid_i && !flush_i) begin
          offload_hs_s = 1'b1;
          state_s      = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (x_issue_ready_i) begin
          issue_hs_s = 1'b1;
          if (x_issue_accept_i) begin
            state_s = COMMIT;
          end else begin
            illegal_s = 1'b1;
            id_inc_s  = 1'b1;
            state_s   = IDLE;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      COMMIT: begin
        kill_s = kill_pending_r | flush_i;
        if (kill_s || !writeback_r) begin
          id_inc_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // Flush is ignored here: the instruction is already committed
        if (x_result_valid_i) begin
          if (x_result_id_i == id_r) begin
            result_take_s = 1'b1;
            rf_we_s       = x_result_we_i;
            id_inc_s      = 1'b1;
            state_s       = IDLE;
          end else begin
            id_err_s = 1'b1;
            state_s  = WAIT_RES;
          end
        end else begin
          state_s = WAIT_RES;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand latches, id counter and registered pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r        <= IDLE;
      instr_r        <= 32'd0;
      rs1_r          <= '0;
      rs2_r          <= '0;
      id_r           <= '0;
      kill_pending_r <= 1'b0;
      writeback_r    <= 1'b0;
      rf_we_r        <= 1'b0;
      rf_waddr_r     <= 5'd0;
      rf_wdata_r     <= '0;
      illegal_r      <= 1'b0;
      id_err_r       <= 1'b0;
    end else begin
      state_r   <= state_s;
      rf_we_r   <= rf_we_s;
      illegal_r <= illegal_s;
      id_err_r  <= id_err_s;
      if (offload_hs_s) begin
        instr_r        <= offload_instr_i;
        rs1_r          <= offload_rs1_i;
        rs2_r          <= offload_rs2_i;
        kill_pending_r <= 1'b0;
      end else if (state_r == ISSUE && flush_i) begin
        kill_pending_r <= 1'b1;
      end else if (state_r != ISSUE) begin
        kill_pending_r <= 1'b0;
      end
      if (issue_hs_s && x_issue_accept_i) begin
        writeback_r <= x_issue_writeback_i;
      end
      if (id_inc_s) begin
        id_r <= id_r + {{(X_ID_WIDTH-1){1'b0}}, 1'b1};
      end
      if (result_take_s) begin
        rf_waddr_r <= x_result_rd_i;
        rf_wdata_r <= x_result_data_i;
      end
    end
  end

  assign offload_ready_o    = (state_r == IDLE) && !flush_i;
  assign x_issue_valid_o    = (state_r == ISSUE);
  assign x_issue_instr_o    = instr_r;
  assign x_issue_id_o       = id_r;
  assign x_issue_rs0_o      = rs1_r;
  assign x_issue_rs1_o      = rs2_r;
  assign x_issue_rs_valid_o = (state_r == ISSUE) ? 2'b11 : 2'b00;
  assign x_commit_valid_o   = (state_r == COMMIT);
  assign x_commit_id_o      = id_r;
  assign x_commit_kill_o    = kill_s;
  assign x_result_ready_o   = (state_r == WAIT_RES);
  assign rf_we_o            = rf_we_r;
  assign rf_waddr_o         = rf_waddr_r;
  assign rf_wdata_o         = rf_wdata_r;
  assign illegal_o          = illegal_r;
  assign id_err_o           = id_err_r;

endmodule

// File: tb/tb_cv32e40x_xif_offload_ctrl.sv
// Randomized bench for the XIF offload controller; a transaction-level model predicts each
// instruction's id and outcome (illegal, killed, no result, write-back) and checks the protocol.
module tb_cv32e40x_xif_offload_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        offload_valid_i, offload_ready_o;
  logic [31:0] offload_instr_i, offload_rs1_i, offload_rs2_i;
  logic        flush_i;
  logic        x_issue_valid_o, x_issue_ready_i;
  logic [31:0] x_issue_instr_o, x_issue_rs0_o, x_issue_rs1_o;
  logic [3:0]  x_issue_id_o;
  logic [1:0]  x_issue_rs_valid_o;
  logic        x_issue_accept_i, x_issue_writeback_i;
  logic        x_commit_valid_o, x_commit_kill_o;
  logic [3:0]  x_commit_id_o;
  logic        x_result_valid_i, x_result_ready_o;
  logic [3:0]  x_result_id_i;
  logic [31:0] x_result_data_i;
  logic [4:0]  x_result_rd_i;
  logic        x_result_we_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        illegal_o, id_err_o;

  int errors = 0;
  int checks = 0;
  int exp_id = 0;

  cv32e40x_xif_offload_ctrl #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .X_RFW_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .offload_valid_i(offload_valid_i), .offload_ready_o(offload_ready_o),
    .offload_instr_i(offload_instr_i), .offload_rs1_i(offload_rs1_i), .offload_rs2_i(offload_rs2_i),
    .flush_i(flush_i),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
    .x_issue_instr_o(x_issue_instr_o), .x_issue_id_o(x_issue_id_o),
    .x_issue_rs0_o(x_issue_rs0_o), .x_issue_rs1_o(x_issue_rs1_o),
    .x_issue_rs_valid_o(x_issue_rs_valid_o),
    .x_issue_accept_i(x_issue_accept_i), .x_issue_writeback_i(x_issue_writeback_i),
    .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o),
    .x_commit_kill_o(x_commit_kill_o),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
    .x_result_rd_i(x_result_rd_i), .x_result_we_i(x_result_we_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .illegal_o(illegal_o), .id_err_o(id_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input string tag);
    check_val({tag, "_ready"},     offload_ready_o,  1'b1);
    check_val({tag, "_issue_v"},   x_issue_valid_o,  1'b0);
    check_val({tag, "_commit_v"},  x_commit_valid_o, 1'b0);
    check_val({tag, "_res_ready"}, x_result_ready_o, 1'b0);
  endtask

  // One offloaded instruction; flush_at = -1 means no flush during issue.
  task automatic run_instr(input int rdy_wait, input int flush_at, input bit accept, input bit wb,
                           input bit flush_commit, input int res_delay, input int bad_ids,
                           input bit we, input bit idle_flush, input bit rst_wait,
                           input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [4:0] rd, input logic [31:0] data);
    logic [3:0] id;
    bit kill;
    id   = 4'(exp_id);
    kill = 1'b0;
    @(negedge clk_i);
    if (idle_flush) begin
      offload_valid_i = 1'b1; flush_i = 1'b1;
      #1 check_val("ready_under_flush", offload_ready_o, 1'b0);
      @(negedge clk_i);
      flush_i = 1'b0;
      #1 check_val("no_issue_after_flush", x_issue_valid_o, 1'b0);
    end
    offload_valid_i = 1'b1; flush_i = 1'b0;
    offload_instr_i = instr; offload_rs1_i = rs1; offload_rs2_i = rs2;
    #1 check_val("offload_ready", offload_ready_o, 1'b1);
    @(negedge clk_i);
    offload_valid_i = 1'b0;
    offload_instr_i = ~instr; offload_rs1_i = ~rs1; offload_rs2_i = ~rs2;
    for (int c = 0; c <= rdy_wait; c++) begin
      x_issue_ready_i     = (c == rdy_wait);
      flush_i             = (c == flush_at);
      x_issue_accept_i    = accept;
      x_issue_writeback_i = wb;
      if (c == flush_at) kill = 1'b1;
      #1;
      check_val("issue_valid", x_issue_valid_o, 1'b1);
      check_val("issue_instr", x_issue_instr_o, instr);
      check_val("issue_id",    x_issue_id_o, id);
      check_val("issue_rs0",   x_issue_rs0_o, rs1);
      check_val("issue_rs1",   x_issue_rs1_o, rs2);
      check_val("issue_rsv",   x_issue_rs_valid_o, 2'b11);
      @(negedge clk_i);
    end
    x_issue_ready_i = 1'b0; flush_i = 1'b0;
    if (!accept) begin
      #1;
      check_val("illegal_pulse", illegal_o, 1'b1);
      check_val("illegal_rf_we", rf_we_o, 1'b0);
      idle_checks("illegal");
      exp_id = (exp_id + 1) % 16;
    end else begin
      flush_i = flush_commit;
      #1;
      check_val("commit_valid", x_commit_valid_o, 1'b1);
      check_val("commit_id",    x_commit_id_o, id);
      check_val("commit_kill",  x_commit_kill_o, kill | flush_commit);
      check_val("no_illegal",   illegal_o, 1'b0);
      kill = kill | flush_commit;
      @(negedge clk_i);
      flush_i = 1'b0;
      if (kill || !wb) begin
        #1;
        check_val("nores_rf_we", rf_we_o, 1'b0);
        idle_checks("nores");
        exp_id = (exp_id + 1) % 16;
      end else if (rst_wait) begin
        rst_i = 1'b1;
        #1 check_val("wait_res_ready", x_result_ready_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        idle_checks("rst_wait");
        check_val("rst_wait_rf_we",   rf_we_o, 1'b0);
        check_val("rst_wait_illegal", illegal_o, 1'b0);
        check_val("rst_wait_id_err",  id_err_o, 1'b0);
        check_val("rst_wait_id",      x_issue_id_o, 4'd0);
        exp_id = 0;
      end else begin
        for (int d = 0; d < res_delay; d++) begin
          flush_i = 1'($urandom_range(0, 1));
          #1 check_val("res_ready_wait", x_result_ready_o, 1'b1);
          @(negedge clk_i);
        end
        flush_i = 1'b0;
        for (int b = 0; b < bad_ids; b++) begin
          x_result_valid_i = 1'b1; x_result_id_i = id + 4'd1;
          x_result_data_i = $urandom; x_result_rd_i = 5'($urandom); x_result_we_i = 1'b1;
          #1 check_val("res_ready_bad", x_result_ready_o, 1'b1);
          @(negedge clk_i);
          check_val("id_err_pulse", id_err_o, 1'b1);
          check_val("bad_no_rf_we", rf_we_o, 1'b0);
        end
        x_result_valid_i = 1'b1; x_result_id_i = id;
        x_result_data_i = data; x_result_rd_i = rd; x_result_we_i = we;
        #1 check_val("res_ready", x_result_ready_o, 1'b1);
        @(negedge clk_i);
        x_result_valid_i = 1'b0;
        #1;
        check_val("rf_we", rf_we_o, we);
        if (we) begin
          check_val("rf_waddr", rf_waddr_o, rd);
          check_val("rf_wdata", rf_wdata_o, data);
        end
        check_val("res_id_err", id_err_o, 1'b0);
        idle_checks("done");
        exp_id = (exp_id + 1) % 16;
      end
    end
    @(negedge clk_i);
    #1;
    check_val("pulse_clear_we",      rf_we_o, 1'b0);
    check_val("pulse_clear_illegal", illegal_o, 1'b0);
    check_val("pulse_clear_id_err",  id_err_o, 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    exp_id = 0;
    #1;
    idle_checks("reset");
    check_val("reset_rf_we",   rf_we_o, 1'b0);
    check_val("reset_illegal", illegal_o, 1'b0);
    check_val("reset_id_err",  id_err_o, 1'b0);
    check_val("reset_rsv",     x_issue_rs_valid_o, 2'b00);
    check_val("reset_kill",    x_commit_kill_o, 1'b0);
  endtask

  initial begin
    offload_valid_i = 1'b0; offload_instr_i = 32'd0; offload_rs1_i = 32'd0; offload_rs2_i = 32'd0;
    flush_i = 1'b0; x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b0; x_issue_writeback_i = 1'b0;
    x_result_valid_i = 1'b0; x_result_id_i = 4'd0; x_result_data_i = 32'd0;
    x_result_rd_i = 5'd0; x_result_we_i = 1'b0;
    do_reset();

    // Directed scenarios
    run_instr(0, -1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0,
              32'h0A000033, 32'h11, 32'h22, 5'd5, 32'hDEADBEEF);
    check_val("next_id_is_1", 64'(exp_id), 64'd1);
    run_instr(0, -1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0,
              $urandom, $urandom, $urandom, 5'd3, $urandom);
    run_instr(3, 1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0,
              $urandom, $urandom, $urandom, 5'd7, $urandom);
    run_instr(0, -1, 1'b1, 1'b1, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0,
              $urandom, $urandom, $urandom, 5'd9, $urandom);
    run_instr(1, -1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0,
              $urandom, $urandom, $urandom, 5'd2, $urandom);
    run_instr(0, -1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1,
              $urandom, $urandom, $urandom, 5'd4, $urandom);

    // Seventeen back-to-back instructions from id 0: covers the 15 -> 0 wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_instr(0, -1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0,
                $urandom, $urandom, $urandom, 5'($urandom), $urandom);
    end
    check_val("wrap_id", 64'(exp_id), 64'd1);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      int rw;
      int fa;
      rw = $urandom_range(0, 3);
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rw)) : -1;
      run_instr(rw, fa, 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 4) != 0),
                1'($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 15) == 0),
                $urandom, $urandom, $urandom, 5'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
